// File: rtl/wb_regfile_stage.sv
// Writeback stage with integrated register file: commits ALU results, serves two
// combinational read ports with same-cycle bypass, and tracks retirement status.
module wb_regfile_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_result_ready,
  input  logic [REG_ADDR_W-1:0] reg_wr_addr,
  input  logic                  reg_wr_en,
  input  logic                  wb_stall,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]       rd_data_a,
  output logic [XLEN-1:0]       rd_data_b,
  output logic [31:0]           retired_count,
  output logic [REG_ADDR_W-1:0] last_wr_addr,
  output logic                  last_wr_valid
);

  localparam int NREGS = 1 << REG_ADDR_W;

  logic [XLEN-1:0] regs [NREGS];
  logic            accept;
  logic            commit;
  logic            bypass_en;

  // Handshake qualification; bypass is suppressed while reset is held.
  always_comb begin
    accept    = alu_result_ready & ~wb_stall;
    commit    = accept & reg_wr_en & (reg_wr_addr != {REG_ADDR_W{1'b0}});
    bypass_en = commit & reset_n;
  end

  // Register array; entry 0 is never written since commit excludes address 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else if (commit) begin
      regs[reg_wr_addr] <= alu_result;
    end
  end

  // Read port A: x0 forced to zero, then bypass, then stored value.
  always_comb begin
    rd_data_a = {XLEN{1'b0}};
    if (rd_addr_a == {REG_ADDR_W{1'b0}}) begin
      rd_data_a = {XLEN{1'b0}};
    end else if (bypass_en && (rd_addr_a == reg_wr_addr)) begin
      rd_data_a = alu_result;
    end else begin
      rd_data_a = regs[rd_addr_a];
    end
  end

  // Read port B mirrors port A so equal addresses always return equal data.
  always_comb begin
    rd_data_b = {XLEN{1'b0}};
    if (rd_addr_b == {REG_ADDR_W{1'b0}}) begin
      rd_data_b = {XLEN{1'b0}};
    end else if (bypass_en && (rd_addr_b == reg_wr_addr)) begin
      rd_data_b = alu_result;
    end else begin
      rd_data_b = regs[rd_addr_b];
    end
  end

  // Retirement counter counts every accepted result and wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_count <= 32'd0;
    end else if (accept) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  // Last-write tracking: address holds between commits, valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_wr_addr  <= {REG_ADDR_W{1'b0}};
      last_wr_valid <= 1'b0;
    end else if (commit) begin
      last_wr_addr  <= reg_wr_addr;
      last_wr_valid <= 1'b1;
    end else begin
      last_wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed plus randomized bench for wb_regfile_stage, checked against an
// architectural model of the register file, retirement counter and last-write status.
module tb_wb_regfile_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] alu_result;
  logic        alu_result_ready;
  logic [4:0]  reg_wr_addr;
  logic        reg_wr_en;
  logic        wb_stall;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] retired_count;
  logic [4:0]  last_wr_addr;
  logic        last_wr_valid;

  wb_regfile_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alu_result       (alu_result),
    .alu_result_ready (alu_result_ready),
    .reg_wr_addr      (reg_wr_addr),
    .reg_wr_en        (reg_wr_en),
    .wb_stall         (wb_stall),
    .rd_addr_a        (rd_addr_a),
    .rd_addr_b        (rd_addr_b),
    .rd_data_a        (rd_data_a),
    .rd_data_b        (rd_data_b),
    .retired_count    (retired_count),
    .last_wr_addr     (last_wr_addr),
    .last_wr_valid    (last_wr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [4:0]  m_last_addr;
  logic        m_last_valid;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a reader should see this cycle before the edge
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reset_n && alu_result_ready && !wb_stall && reg_wr_en &&
        reg_wr_addr != 5'd0 && a == reg_wr_addr) return alu_result;
    return m_regs[a];
  endfunction

  task automatic step(input logic rn, input logic rdy, input logic we, input logic stl,
                      input logic [4:0] wa, input logic [31:0] val,
                      input logic [4:0] ra, input logic [4:0] rb, input bit chk_rd);
    @(negedge clk);
    reset_n = rn; alu_result_ready = rdy; reg_wr_en = we; wb_stall = stl;
    reg_wr_addr = wa; alu_result = val; rd_addr_a = ra; rd_addr_b = rb;
    #1;
    if (chk_rd) begin
      check("rd_data_a", rd_data_a, exp_read(ra));
      check("rd_data_b", rd_data_b, exp_read(rb));
    end
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0; m_last_addr = 5'd0; m_last_valid = 1'b0;
    end else if (rdy && !stl) begin
      m_cnt = m_cnt + 32'd1;
      if (we && wa != 5'd0) begin
        m_regs[wa] = val; m_last_addr = wa; m_last_valid = 1'b1;
      end else begin
        m_last_valid = 1'b0;
      end
    end else begin
      m_last_valid = 1'b0;
    end
    #1;
    check("retired_count", retired_count, m_cnt);
    check("last_wr_addr", {27'd0, last_wr_addr}, {27'd0, m_last_addr});
    check("last_wr_valid", {31'd0, last_wr_valid}, {31'd0, m_last_valid});
  endtask

  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, ra, rb, 1'b1);
  endtask

  initial begin
    logic rn, rdy, we, stl;
    logic [4:0] wa, ra, rb;
    logic [31:0] val;

    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0; m_last_addr = 5'd0; m_last_valid = 1'b0;

    // Reset; register contents are unknown before the first edge
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1);
    check("reset_count", retired_count, 32'd0);

    // Basic write to x5
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd1, 5'd2, 1'b1);
    check("basic_count", retired_count, 32'd1);
    check("basic_valid", {31'd0, last_wr_valid}, 32'd1);
    idle_read(5'd5, 5'd5);
    check("basic_valid_drop", {31'd0, last_wr_valid}, 32'd0);

    // Write to x0 is discarded but counted
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1);
    check("x0_read", rd_data_a, 32'd0);
    check("x0_count", retired_count, 32'd2);

    // Bypass on both ports to the same address
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 1'b1);
    idle_read(5'd7, 5'd5);

    // Stall: no write, no count, no bypass
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0042, 5'd0, 5'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd3, 1'b1);
    idle_read(5'd3, 5'd3);

    // Bubble: ready low with write enable set
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'hFFFF_0000, 5'd4, 5'd4, 1'b1);
    idle_read(5'd4, 5'd4);

    // Fill x1..x31 then reset with a pending commit to x9
    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 5'(i), 32'h1000_0000 + 32'(i), 5'(i), 5'(i - 1), 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9, 1'b1);
    for (int i = 0; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));

    // Counter wrap via preload of the counter register
    @(negedge clk);
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'd0, 5'd0, 5'd0, 1'b1);
    check("wrap_count", retired_count, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rn  = ($urandom_range(0, 39) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 4) == 0);
      wa  = 5'($urandom_range(0, 31));
      val = $urandom;
      ra  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step(rn, rdy, we, stl, wa, val, ra, rb, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
